// File: rtl/control_unit_pipe.sv
// control_unit_pipe
//   Decode-stage control unit for a 5-stage RV32I pipeline. It decodes instr_d,
//   registers the control bundle into the D->E pipeline register, detects
//   load-use hazards and inserts its own bubble, and flags and counts illegal
//   instructions.
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   valid_d         instr_d holds a real instruction
//   instr_d         instruction word in D
//   flush_e         taken redirect: E is loaded with a bubble on the next edge
//   stall_d         combinational load-use stall request to the F/D registers
//   *_e             registered E-stage control bundle (1-cycle latency)
//   illegal_cnt     saturating count of illegal instructions that entered E
module control_unit_pipe #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_d,
  input  logic [31:0]          instr_d,
  input  logic                 flush_e,
  output logic                 stall_d,
  output logic                 valid_e,
  output logic                 reg_write_e,
  output logic [1:0]           result_src_e,
  output logic                 mem_write_e,
  output logic                 jump_e,
  output logic                 jalr_e,
  output logic                 branch_e,
  output logic [2:0]           branch_type_e,
  output logic [ALUCTRL_W-1:0] alu_control_e,
  output logic                 alu_src_a_e,
  output logic                 alu_src_b_e,
  output logic [2:0]           imm_src_e,
  output logic [4:0]           rd_e,
  output logic                 illegal_e,
  output logic [CNT_W-1:0]     illegal_cnt
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic [2:0] branch_type;
    logic [3:0] alu;
    logic       src_a;
    logic       src_b;
    logic [2:0] imm_src;
    logic [4:0] rd;
    logic       illegal;
  } ectl_t;

  localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_OR  = 4'h3,
                         A_XOR = 4'h4, A_SLT = 4'h5, A_SLTU = 4'h6, A_SLL = 4'h7,
                         A_SRL = 4'h8, A_SRA = 4'h9, A_PASSB = 4'hA;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                         IMM_J = 3'b011, IMM_U = 3'b100;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign op  = instr_d[6:0];
  assign rd  = instr_d[11:7];
  assign f3  = instr_d[14:12];
  assign rs1 = instr_d[19:15];
  assign rs2 = instr_d[24:20];
  assign f7  = instr_d[31:25];

  ectl_t dec, e_d, e_q;
  logic  ill, uses_rs1, uses_rs2;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Plain funct3 -> ALU op mapping shared by OP and OP-IMM; alt selects sra.
  function automatic logic [3:0] alu_f3(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  alu_f3 = A_ADD;
      3'b001:  alu_f3 = A_SLL;
      3'b010:  alu_f3 = A_SLT;
      3'b011:  alu_f3 = A_SLTU;
      3'b100:  alu_f3 = A_XOR;
      3'b101:  alu_f3 = alt ? A_SRA : A_SRL;
      3'b110:  alu_f3 = A_OR;
      default: alu_f3 = A_AND;
    endcase
  endfunction

  always_comb begin
    dec      = '0;
    ill      = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (op)
      7'b0000011: begin // lw
        uses_rs1 = 1'b1;
        ill = (f3 != 3'b010);
        dec.reg_write = 1'b1; dec.result_src = 2'b01; dec.src_b = 1'b1; dec.imm_src = IMM_I;
      end
      7'b0100011: begin // sw
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ill = (f3 != 3'b010);
        dec.mem_write = 1'b1; dec.src_b = 1'b1; dec.imm_src = IMM_S;
      end
      7'b0010011: begin // OP-IMM; only shifts constrain funct7, addi never becomes sub
        uses_rs1 = 1'b1;
        dec.reg_write = 1'b1; dec.src_b = 1'b1; dec.imm_src = IMM_I;
        dec.alu = alu_f3(f3, instr_d[30]);
        if (f3 == 3'b001) ill = (f7 != 7'h00);
        if (f3 == 3'b101) ill = (f7 != 7'h00) && (f7 != 7'h20);
      end
      7'b0110011: begin // OP
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.reg_write = 1'b1;
        if (f7 == 7'h00)                                dec.alu = alu_f3(f3, 1'b0);
        else if (f7 == 7'h20 && f3 == 3'b000)           dec.alu = A_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101)           dec.alu = A_SRA;
        else                                            ill = 1'b1;
      end
      7'b1100011: begin // branch: compare via sub, funct3 carried to E
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        dec.branch = 1'b1; dec.branch_type = f3; dec.alu = A_SUB; dec.imm_src = IMM_B;
      end
      7'b1101111: begin // jal
        dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.jump = 1'b1; dec.imm_src = IMM_J;
      end
      7'b1100111: begin // jalr
        uses_rs1 = 1'b1;
        ill = (f3 != 3'b000);
        dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.jump = 1'b1; dec.jalr = 1'b1;
        dec.src_b = 1'b1; dec.imm_src = IMM_I;
      end
      7'b0110111: begin // lui
        dec.reg_write = 1'b1; dec.alu = A_PASSB; dec.src_b = 1'b1; dec.imm_src = IMM_U;
      end
      7'b0010111: begin // auipc
        dec.reg_write = 1'b1; dec.src_a = 1'b1; dec.src_b = 1'b1; dec.imm_src = IMM_U;
      end
      default: ill = 1'b1;
    endcase
    // rd only meaningful when the instruction writes; store/branch rd field is immediate bits
    dec.rd = dec.reg_write ? rd : 5'd0;
    if (ill) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
    dec.valid = 1'b1;
  end

  assign stall_d = (HAZARD_EN != 0) && valid_d && e_q.valid && (e_q.result_src == 2'b01) &&
                   (e_q.rd != 5'd0) &&
                   ((uses_rs1 && rs1 == e_q.rd) || (uses_rs2 && rs2 == e_q.rd));

  always_comb begin
    e_d = '0; // bubble
    if (!flush_e && !stall_d && valid_d) e_d = dec;
    cnt_d = cnt_q;
    if (e_d.illegal && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_e       = e_q.valid;
  assign reg_write_e   = e_q.reg_write;
  assign result_src_e  = e_q.result_src;
  assign mem_write_e   = e_q.mem_write;
  assign jump_e        = e_q.jump;
  assign jalr_e        = e_q.jalr;
  assign branch_e      = e_q.branch;
  assign branch_type_e = e_q.branch_type;
  assign alu_control_e = ALUCTRL_W'(e_q.alu);
  assign alu_src_a_e   = e_q.src_a;
  assign alu_src_b_e   = e_q.src_b;
  assign imm_src_e     = e_q.imm_src;
  assign rd_e          = e_q.rd;
  assign illegal_e     = e_q.illegal;
  assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: a vector table for single-instruction
// decode plus hand sequences for saturation, load-use, flush and reset corners.
module tb_control_unit_pipe;

  logic        clk = 1'b0;
  logic        reset, valid_d, flush_e;
  logic [31:0] instr_d;
  logic        stall_d, valid_e, reg_write_e, mem_write_e, jump_e, jalr_e, branch_e;
  logic        alu_src_a_e, alu_src_b_e, illegal_e;
  logic [1:0]  result_src_e;
  logic [2:0]  branch_type_e, imm_src_e;
  logic [3:0]  alu_control_e;
  logic [4:0]  rd_e;
  logic [1:0]  illegal_cnt;

  int tests = 0, fails = 0;

  control_unit_pipe #(.ALUCTRL_W(4), .CNT_W(2), .HAZARD_EN(1)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .instr_d(instr_d), .flush_e(flush_e),
    .stall_d(stall_d), .valid_e(valid_e), .reg_write_e(reg_write_e),
    .result_src_e(result_src_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
    .jalr_e(jalr_e), .branch_e(branch_e), .branch_type_e(branch_type_e),
    .alu_control_e(alu_control_e), .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
    .imm_src_e(imm_src_e), .rd_e(rd_e), .illegal_e(illegal_e), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  logic [25:0] got;
  assign got = {valid_e, reg_write_e, result_src_e, mem_write_e, jump_e, jalr_e, branch_e,
                branch_type_e, alu_control_e, alu_src_a_e, alu_src_b_e, imm_src_e, rd_e,
                illegal_e};

  function automatic logic [25:0] ex(int v, int rw, int rs, int mw, int j, int jr, int b,
                                     int bt, int alu, int sa, int sb, int imm, int rd, int il);
    ex = {v[0], rw[0], rs[1:0], mw[0], j[0], jr[0], b[0], bt[2:0], alu[3:0], sa[0], sb[0],
          imm[2:0], rd[4:0], il[0]};
  endfunction

  function automatic logic [31:0] rt(int f7, int r2, int r1, int f3, int rd, int op);
    rt = {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        fl;
    logic [25:0] exp;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[21];

  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw x0,0(x1)

  initial begin
    tbl[0]  = '{32'h402080B3,          1, 0, ex(1,1,0,0,0,0,0,0,1,0,0,0,1,0), 0};  // sub x1
    tbl[1]  = '{rt(0,2,5,0,6,'h33),    1, 0, ex(1,1,0,0,0,0,0,0,0,0,0,0,6,0), 0};  // add
    tbl[2]  = '{rt('h20,2,1,5,7,'h33), 1, 0, ex(1,1,0,0,0,0,0,0,9,0,0,0,7,0), 0};  // sra
    tbl[3]  = '{rt(0,2,1,3,8,'h33),    1, 0, ex(1,1,0,0,0,0,0,0,6,0,0,0,8,0), 0};  // sltu
    tbl[4]  = '{rt('h20,2,1,4,9,'h33), 1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,1), 1};  // bad xor
    tbl[5]  = '{rt(0,5,1,0,10,'h13),   1, 0, ex(1,1,0,0,0,0,0,0,0,0,1,0,10,0), 1}; // addi
    tbl[6]  = '{rt('h20,0,1,0,11,'h13),1, 0, ex(1,1,0,0,0,0,0,0,0,0,1,0,11,0), 1}; // addi b30
    tbl[7]  = '{rt('h20,3,1,5,12,'h13),1, 0, ex(1,1,0,0,0,0,0,0,9,0,1,0,12,0), 1}; // srai
    tbl[8]  = '{rt(0,2,1,5,13,'h13),   1, 0, ex(1,1,0,0,0,0,0,0,8,0,1,0,13,0), 1}; // srli
    tbl[9]  = '{rt('h20,3,1,1,14,'h13),1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,1), 2};  // bad slli
    tbl[10] = '{32'h123451B7,          1, 0, ex(1,1,0,0,0,0,0,0,10,0,1,4,3,0), 2}; // lui
    tbl[11] = '{32'h00001217,          1, 0, ex(1,1,0,0,0,0,0,0,0,1,1,4,4,0), 2};  // auipc x4
    tbl[12] = '{rt(0,2,1,2,8,'h23),    1, 0, ex(1,0,0,1,0,0,0,0,0,0,1,1,0,0), 2};  // sw
    tbl[13] = '{rt(0,2,1,6,0,'h63),    1, 0, ex(1,0,0,0,0,0,1,6,1,0,0,2,0,0), 2};  // bltu
    tbl[14] = '{32'h000000EF,          1, 0, ex(1,1,2,0,1,0,0,0,0,0,0,3,1,0), 2};  // jal x1
    tbl[15] = '{rt(0,0,2,0,1,'h67),    1, 0, ex(1,1,2,0,1,1,0,0,0,0,1,0,1,0), 2};  // jalr
    tbl[16] = '{rt(0,0,2,1,1,'h67),    1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,1), 3};  // bad jalr
    tbl[17] = '{rt(0,2,1,2,0,'h63),    1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,1), 3};  // bad br, sat
    tbl[18] = '{rt(0,2,1,0,0,'h63),    1, 1, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 3};  // beq+flush
    tbl[19] = '{rt(0,2,1,0,6,'h33),    0, 0, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 3};  // not valid
    tbl[20] = '{32'h0000007F,          1, 1, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 3};  // flushed illegal

    // reset held two cycles with an add on instr_d
    reset = 1; valid_d = 1; flush_e = 0; instr_d = rt(0,2,1,0,3,'h33);
    step(); step();
    chk("reset_ctl", 32'(got), 32'd0);
    chk("reset_cnt", 32'(illegal_cnt), 32'd0);
    chk("reset_stall", 32'(stall_d), 32'd0);

    // illegal opcode streamed: counter saturates at 3 with CNT_W=2
    reset = 0; instr_d = 32'h0000007F;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ill_e_%0d", i), 32'(illegal_e), 32'd1);
      chk($sformatf("ill_v_%0d", i), 32'(valid_e), 32'd1);
      chk($sformatf("ill_cnt_%0d", i), 32'(illegal_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    reset = 1; step(); reset = 0;
    chk("cnt_cleared", 32'(illegal_cnt), 32'd0);

    for (int i = 0; i < 21; i++) begin
      instr_d = tbl[i].instr; valid_d = tbl[i].vld; flush_e = tbl[i].fl;
      step();
      chk($sformatf("vec%0d_ctl", i), 32'(got), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(illegal_cnt), 32'(tbl[i].cnt));
    end
    valid_d = 1; flush_e = 0;

    // load-use: lw x5 then add x6,x5,x2 -> one bubble then add
    instr_d = LW_X5; step();
    chk("lw_e_src", 32'(result_src_e), 32'd1);
    chk("lw_e_rd", 32'(rd_e), 32'd5);
    instr_d = rt(0,2,5,0,6,'h33); #1;
    chk("lu_stall", 32'(stall_d), 32'd1);
    step();
    chk("lu_bubble", 32'(got), 32'd0);
    chk("lu_stall_drop", 32'(stall_d), 32'd0);
    step();
    chk("lu_add_in", 32'(got), 32'(ex(1,1,0,0,0,0,0,0,0,0,0,0,6,0)));

    // store data dependency on rs2 stalls
    instr_d = LW_X5; step();
    instr_d = rt(0,5,1,2,0,'h23); #1;
    chk("lu_sw_rs2", 32'(stall_d), 32'd1);
    // addi whose rs2 field matches does not stall
    instr_d = rt(0,5,1,0,7,'h13); #1;
    chk("lu_addi_nors2", 32'(stall_d), 32'd0);
    // lui whose rs1 field matches does not stall
    instr_d = 32'h000281B7; #1;
    chk("lu_lui_nors1", 32'(stall_d), 32'd0);
    // dependent but valid_d low: no stall
    instr_d = rt(0,2,5,0,6,'h33); valid_d = 0; #1;
    chk("lu_invalid_d", 32'(stall_d), 32'd0);
    valid_d = 1;

    // flush and stall together: bubble, stall still raised
    flush_e = 1; #1;
    chk("fl_st_stall", 32'(stall_d), 32'd1);
    step(); flush_e = 0;
    chk("fl_st_bubble", 32'(valid_e), 32'd0);

    // load to x0 never stalls
    instr_d = LW_X0; step();
    instr_d = rt(0,0,0,0,6,'h33); #1;
    chk("lu_x0", 32'(stall_d), 32'd0);

    // reset while stalled
    instr_d = LW_X5; step();
    instr_d = rt(0,2,5,0,6,'h33); #1;
    chk("rst_st_pre", 32'(stall_d), 32'd1);
    reset = 1; step(); reset = 0;
    chk("rst_st_bubble", 32'(valid_e), 32'd0);
    chk("rst_st_drop", 32'(stall_d), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
